pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Turns the raw hazard indications into per-stage enable and clear strobes for PC, IF_ID, ID_EX, EX_MEM and MEM_WB:
  - load-use bubble from the redirection unit
  - taken-branch/jump control clash from EX
  - syscall halt from the statistic unit
- Owns the run/drain/halt state machine, resumes on the restart button, and counts stall and flush cycles for the display.

Parameters:
- DRAIN_CYCLES, 2, cycles that EX_MEM and MEM_WB keep advancing after a halt before the pipeline freezes (1..7).
- CNT_W, 32, width of the stall and flush counters.

Ports:
- clk  in  1  pipeline clock (after frequency_switch).
- rst  in  1  asynchronous, active-low reset.
- bubble  in  1  load-use hazard detected in ID (same cycle).
- ctrl_clash  in  1  EX redirects PC (npc != pc_4_EXE).
- halt  in  1  syscall halt request from EX (already qualified by stop).
- restart  in  1  restart button level, synchronous to clk.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF_ID load enable.
- if_id_clr  out  1  IF_ID synchronous clear (insert nop).
- id_ex_en  out  1  ID_EX load enable.
- id_ex_clr  out  1  ID_EX synchronous clear.
- ex_mem_en  out  1  EX_MEM load enable.
- mem_wb_en  out  1  MEM_WB load enable.
- halted  out  1  high in HALTED state.
- stall_cnt  out  CNT_W  cycles with bubble honoured.
- flush_cnt  out  CNT_W  cycles with ctrl_clash honoured.

Behaviour:
- States: RUN, DRAIN, HALTED. The state register and a 3-bit drain counter are registered. Strobes are combinational from the state and the same-cycle hazard inputs, with zero latency.
- Reset (rst=0, async):
  - state=RUN, drain counter=0, restart_q=0, stall_cnt=0, flush_cnt=0.
  - Outputs take their RUN-idle values: all *_en=1, all *_clr=0, halted=0.
- RUN priority, highest first: halt > ctrl_clash > bubble > idle.
  - halt:
    - pc_en=0, if_id_en=0 (hold the younger instructions).
    - id_ex_clr=1, so the syscall retires into EX_MEM and EX becomes a nop.
    - ex_mem_en=1, mem_wb_en=1.
    - Next state DRAIN, drain counter=DRAIN_CYCLES-1.
  - ctrl_clash:
    - pc_en=1 (loads npc).
    - if_id_clr=1, id_ex_clr=1, other enables 1.
    - flush_cnt+1.
  - bubble:
    - pc_en=0, if_id_en=0.
    - id_ex_clr=1, ex_mem_en=1, mem_wb_en=1.
    - stall_cnt+1.
  - idle: all enables 1, clears 0.
- DRAIN:
  - pc_en=if_id_en=id_ex_en=0, clears 0.
  - ex_mem_en=mem_wb_en=1.
  - Hazard inputs are ignored and counters do not count.
  - Counter decrements each cycle. When it is 0, the next state is HALTED.
- HALTED:
  - All enables 0, all clears 0, halted=1.
  - A restart rising edge (restart & ~restart_q) moves the state to RUN next cycle. Execution resumes at the held IF/ID instruction (syscall+4).
- restart_q is registered every cycle in every state. A restart edge in RUN or DRAIN is ignored; a held button does not retrigger.
- In the first RUN cycle after restart, EX holds a nop, so a stale halt cannot occur. If halt is asserted anyway, it is honoured.
- Counters wrap modulo 2^CNT_W.
- Simultaneous ctrl_clash and bubble: flush only. flush_cnt increments, stall_cnt does not.
- Reset asserted mid-DRAIN or in HALTED returns immediately to RUN with counters cleared.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
  - the default DRAIN_CYCLES constant
  - a strobe-bundle ordering constant {pc, if_id, id_ex, ex_mem, mem_wb}
- One natural sub-module: restart_edge, a registered rising-edge detector with async active-low reset.

Test Plan:
- Reset then idle, with all inputs 0 for 5 cycles -> all *_en=1, clears 0, halted=0, stall_cnt=flush_cnt=0.
- One-cycle bubble pulse -> that cycle pc_en=0, if_id_en=0, id_ex_clr=1, ex_mem_en=1; stall_cnt=1 next cycle.
- ctrl_clash and bubble together for 1 cycle -> pc_en=1, if_id_clr=1, id_ex_clr=1; flush_cnt=1, stall_cnt=0.
- halt pulse with DRAIN_CYCLES=2 -> cycle 0: id_ex_clr=1, pc_en=0; cycles 1-2: ex_mem_en=1, pc_en=0; cycle 3 onward: halted=1, all en 0. bubble pulses during DRAIN leave stall_cnt unchanged.
- In HALTED, restart held high for 10 cycles -> exactly one transition to RUN one cycle after the edge; a second press while in RUN has no effect.
- rst pulsed low during DRAIN with stall_cnt=7 -> immediately state RUN, stall_cnt=0, halted=0, all en=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encoding, drain default and strobe-bundle bit order.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DRAIN_CYCLES_DEF = 2;

  // Strobe bundle order: {pc, if_id, id_ex, ex_mem, mem_wb}
  localparam int STB_W      = 5;
  localparam int STB_PC     = 4;
  localparam int STB_IF_ID  = 3;
  localparam int STB_ID_EX  = 2;
  localparam int STB_EX_MEM = 1;
  localparam int STB_MEM_WB = 0;

  localparam logic [STB_W-1:0] STB_ALL  = 5'b11111;
  localparam logic [STB_W-1:0] STB_NONE = 5'b00000;
  localparam logic [STB_W-1:0] STB_BACK = 5'b00011;

endpackage

// File: rtl/pipeline_hazard_ctrl_restart_edge.sv
// Registered rising-edge detector for the restart button.
// The delayed copy is kept every cycle so a held button fires once.
module restart_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  // Delay the button level by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stage strobes, run/drain/halt FSM,
// and stall/flush cycle counters for the display.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             ctrl_clash,
  input  logic             halt,
  input  logic             restart,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_en,
  output logic             id_ex_clr,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state, state_nxt;
  logic [2:0]       drain_cnt, drain_nxt;
  logic [STB_W-1:0] en;
  logic             if_clr, id_clr;
  logic             stall_inc, flush_inc;
  logic             rise;

  restart_edge u_restart_edge (
    .clk  (clk),
    .rst_n(rst),
    .d    (restart),
    .rise (rise)
  );

  // Strobes and next state, zero latency from the hazard inputs
  always_comb begin
    en        = STB_ALL;
    if_clr    = 1'b0;
    id_clr    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          halt: begin
            en[STB_PC]    = 1'b0;
            en[STB_IF_ID] = 1'b0;
            id_clr        = 1'b1;
            state_nxt     = DRAIN;
            drain_nxt     = 3'(DRAIN_CYCLES - 1);
          end
          (!halt && ctrl_clash): begin
            if_clr    = 1'b1;
            id_clr    = 1'b1;
            flush_inc = 1'b1;
          end
          (!halt && !ctrl_clash && bubble): begin
            en[STB_PC]    = 1'b0;
            en[STB_IF_ID] = 1'b0;
            id_clr        = 1'b1;
            stall_inc     = 1'b1;
          end
          default: ;
        endcase
      end
      DRAIN: begin
        en = STB_BACK;
        if (drain_cnt == 3'd0) begin
          state_nxt = HALTED;
        end else begin
          drain_nxt = drain_cnt - 3'd1;
        end
      end
      HALTED: begin
        en = STB_NONE;
        if (rise) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, drain counter and hazard counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_en     = en[STB_PC];
  assign if_id_en  = en[STB_IF_ID];
  assign id_ex_en  = en[STB_ID_EX];
  assign ex_mem_en = en[STB_EX_MEM];
  assign mem_wb_en = en[STB_MEM_WB];
  assign if_id_clr = if_clr;
  assign id_ex_clr = id_clr;
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: behavioural model checked every
// cycle plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bubble = 1'b0;
  logic        ctrl_clash = 1'b0;
  logic        halt = 1'b0;
  logic        restart = 1'b0;
  logic        pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
  logic        ex_mem_en, mem_wb_en, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .ctrl_clash(ctrl_clash),
    .halt      (halt),
    .restart   (restart),
    .pc_en     (pc_en),
    .if_id_en  (if_id_en),
    .if_id_clr (if_id_clr),
    .id_ex_en  (id_ex_en),
    .id_ex_clr (id_ex_clr),
    .ex_mem_en (ex_mem_en),
    .mem_wb_en (mem_wb_en),
    .halted    (halted),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: mode 0 running, 1 draining, 2 halted
  int          m_mode;
  int          m_left;
  bit          m_prev;
  int unsigned m_stall, m_flush;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_left = 0; m_prev = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      bit fire;
      fire = restart && !m_prev;
      m_prev = restart;
      if (m_mode == 0) begin
        if (halt) begin
          m_mode = 1;
          m_left = DC;
        end else if (ctrl_clash) m_flush++;
        else if (bubble) m_stall++;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end else if (fire) begin
        m_mode = 0;
      end
    end
  end

  function automatic logic [7:0] expect_stb();
    logic stop_front;
    if (m_mode == 1) return 8'b0000_0110;
    if (m_mode == 2) return 8'b0000_0001;
    stop_front = halt || (!ctrl_clash && bubble);
    return {!stop_front, !stop_front, !halt && ctrl_clash, 1'b1,
            halt || ctrl_clash || bubble, 1'b1, 1'b1, 1'b0};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] act, exp_v;
    act = {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
           ex_mem_en, mem_wb_en, halted};
    exp_v = expect_stb();
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL model_strobes t=%0t got=%b want=%b", $time, act, exp_v);
    end
    checks++;
    if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
      failures++;
      $display("FAIL model_counters t=%0t got=%0d/%0d want=%0d/%0d",
               $time, stall_cnt, flush_cnt, m_stall, m_flush);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
    end
  endtask

  task automatic drive(input bit b, input bit c, input bit h, input bit r);
    bubble = b; ctrl_clash = c; halt = h; restart = r;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    int runs;
    drive(0, 0, 0, 0);
    repeat (2) next();
    rst = 1'b1;
    repeat (5) next();
    mid();
    chk("idle_pc_en", pc_en, 1);
    chk("idle_mem_wb_en", mem_wb_en, 1);
    chk("idle_clr", {if_id_clr, id_ex_clr}, 0);
    chk("idle_halted", halted, 0);
    chk("idle_stall", stall_cnt, 0);
    next();

    drive(1, 0, 0, 0);
    mid();
    chk("bubble_pc_en", pc_en, 0);
    chk("bubble_if_id_en", if_id_en, 0);
    chk("bubble_id_ex_clr", id_ex_clr, 1);
    chk("bubble_ex_mem_en", ex_mem_en, 1);
    next();
    drive(0, 0, 0, 0);
    mid();
    chk("bubble_stall_cnt", stall_cnt, 1);
    next();

    drive(1, 1, 0, 0);
    mid();
    chk("clash_pc_en", pc_en, 1);
    chk("clash_if_id_clr", if_id_clr, 1);
    chk("clash_id_ex_clr", id_ex_clr, 1);
    next();
    drive(0, 0, 0, 0);
    mid();
    chk("clash_flush_cnt", flush_cnt, 1);
    chk("clash_stall_cnt", stall_cnt, 1);
    next();

    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0);
      next();
    end
    drive(0, 0, 0, 0);
    mid();
    chk("stall_seven", stall_cnt, 7);
    next();

    drive(0, 0, 1, 0);
    mid();
    chk("halt0_pc_en", pc_en, 0);
    chk("halt0_id_ex_clr", id_ex_clr, 1);
    chk("halt0_ex_mem_en", ex_mem_en, 1);
    next();
    for (int i = 1; i <= 2; i++) begin
      drive(1, 0, 0, 0);
      mid();
      chk("drain_pc_en", pc_en, 0);
      chk("drain_ex_mem_en", ex_mem_en, 1);
      chk("drain_halted", halted, 0);
      next();
    end
    drive(0, 0, 0, 0);
    mid();
    chk("halted_flag", halted, 1);
    chk("halted_ex_mem_en", ex_mem_en, 0);
    chk("halted_mem_wb_en", mem_wb_en, 0);
    chk("drain_stall_kept", stall_cnt, 7);
    next();
    next();

    runs = 0;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      mid();
      if (!halted) runs++;
      next();
    end
    chk("restart_single_edge", runs, 9);
    drive(0, 0, 0, 0);
    next();
    drive(0, 0, 0, 1);
    mid();
    next();
    mid();
    chk("repress_run_halted", halted, 0);
    chk("repress_run_pc_en", pc_en, 1);
    next();
    drive(0, 0, 0, 0);
    next();

    drive(0, 0, 1, 0);
    next();
    drive(0, 0, 0, 0);
    mid();
    chk("drain2_pc_en", pc_en, 0);
    #1 rst = 1'b0;
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    next();
    rst = 1'b1;
    repeat (3) next();
    mid();
    chk("post_rst_ex_mem_en", ex_mem_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
